tx_frontend: RTL and testbench

- Serial UART transmitter, the transmit-side counterpart of the existing receive front end.
- Accepts one data word per valid/ready handshake and serialises it LSB-first on uart_tx_o.
- Frame format comes from the same control-register fields as the receiver: clock divider, data size, parity and stop bits.
- Sits between the Wishbone register/FIFO logic and the TX pad.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/tx_frontend_baud_gen.sv | 26 ++
 rtl/tx_frontend.sv | 139 +++++++++++++
 tb/tb_tx_frontend.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmit and receive front ends.
// Contents: parity encodings, packet size limits, transmitter state type and
// a parity helper used when a word is captured.
package uart_pkg;

   localparam logic [1:0] PARITY_NONE = 2'b00;
   localparam logic [1:0] PARITY_EVEN = 2'b01;
   localparam logic [1:0] PARITY_ODD  = 2'b10;

   localparam int MIN_PACKET_SIZE = 8;
   localparam int MAX_PACKET_SIZE = 11;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP,
      TX_BREAK
   } tx_state_e;

   // Both 2'b10 and 2'b11 select odd parity, so bit 1 alone means "invert".
   function automatic logic calc_parity(input logic [7:0] data, input logic ds, input logic [1:0] p);
      return (^{data[7] & ds, data[6:0]}) ^ p[1];
   endfunction

endpackage

// File: rtl/tx_frontend_baud_gen.sv
// baud_gen: loadable 16-bit down-counter that marks the last cycle of a bit.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          reload the counter with load_val_i this edge
//   load_val_i      bit period minus one
//   bit_end_o       high while the counter reads zero (final cycle of the bit)
module baud_gen (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   output logic        bit_end_o
);

   logic [15:0] cnt_q, cnt_d;

   always_comb cnt_d = load_i ? load_val_i : (cnt_q != 16'd0 ? cnt_q - 16'd1 : cnt_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= 16'd0;
      else         cnt_q <= cnt_d;
   end

   assign bit_end_o = cnt_q == 16'd0;

endmodule

// File: rtl/tx_frontend.sv
// tx_frontend: UART transmitter, serialises one handshaked word LSB-first.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cr_clk_div_i             cycles per bit (0 and 1 both mean 1)
//   cr_ds_i                  data size: 0 = 7 bits, 1 = 8 bits
//   cr_p_i                   parity: 00 none, 01 even, 1x odd
//   cr_s_i                   stop bits: 0 = one, 1 = two
//   data_i, valid_i, ready_o word handshake
//   break_i                  hold line low while idle (only with TX_BREAK_EN)
//   uart_tx_o                serial line, idle high, registered
//   busy_o                   frame or break in progress
// Optional feature macro: TX_BREAK_EN adds break_i.
module tx_frontend
   import uart_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] cr_clk_div_i,
   input  logic        cr_ds_i,
   input  logic [1:0]  cr_p_i,
   input  logic        cr_s_i,
   input  logic [7:0]  data_i,
   input  logic        valid_i,
`ifdef TX_BREAK_EN
   input  logic        break_i,
`endif
   output logic        ready_o,
   output logic        uart_tx_o,
   output logic        busy_o
);

   tx_state_e   state_q, state_d;
   logic [7:0]  sh_q, sh_d;
   logic [15:0] div_q, div_d, div_new;
   logic [3:0]  idx_q, idx_d;
   logic [1:0]  p_q, p_d;
   logic        ds_q, ds_d, s_q, s_d, par_q, par_d, tx_q, tx_d;
   logic        bit_end, accept, brk;

`ifdef TX_BREAK_EN
   assign brk = break_i;
`else
   assign brk = 1'b0;
`endif

   assign ready_o = (state_q == TX_IDLE) && !brk;
   assign busy_o  = !ready_o;
   assign accept  = valid_i && ready_o;
   assign div_new = (cr_clk_div_i == 16'd0) ? 16'd0 : cr_clk_div_i - 16'd1;

   // Every bit start reloads the period; the first one comes from the live CR.
   baud_gen u_baud (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (accept || bit_end),
      .load_val_i (accept ? div_new : div_q),
      .bit_end_o  (bit_end)
   );

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      div_d   = div_q;
      idx_d   = idx_q;
      ds_d    = ds_q;
      p_d     = p_q;
      s_d     = s_q;
      par_d   = par_q;
      case (state_q)
         TX_IDLE:
            if (accept) begin
               state_d = TX_START;
               sh_d    = data_i;
               div_d   = div_new;
               ds_d    = cr_ds_i;
               p_d     = cr_p_i;
               s_d     = cr_s_i;
               par_d   = calc_parity(data_i, cr_ds_i, cr_p_i);
            end else if (brk) state_d = TX_BREAK;
         TX_START:
            if (bit_end) begin
               state_d = TX_DATA;
               idx_d   = 4'd0;
            end
         TX_DATA:
            if (bit_end) begin
               if (idx_q == (ds_q ? 4'd7 : 4'd6)) begin
                  state_d = (p_q != PARITY_NONE) ? TX_PARITY : TX_STOP;
                  idx_d   = 4'd0;
               end else begin
                  idx_d = idx_q + 4'd1;
                  sh_d  = {1'b0, sh_q[7:1]};
               end
            end
         TX_PARITY:
            if (bit_end) state_d = TX_STOP;
         TX_STOP:
            if (bit_end) begin
               if (idx_q == {3'b000, s_q}) state_d = TX_IDLE;
               else                        idx_d = idx_q + 4'd1;
            end
         // The line is released first; IDLE (and ready) follows one cycle later.
         TX_BREAK:
            if (!brk && tx_q) state_d = TX_IDLE;
         default: state_d = TX_IDLE;
      endcase
      tx_d = (state_d == TX_START)  ? 1'b0 :
             (state_d == TX_DATA)   ? sh_d[0] :
             (state_d == TX_PARITY) ? par_q :
             (state_d == TX_BREAK)  ? !brk : 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= TX_IDLE;
         sh_q    <= 8'd0;
         div_q   <= 16'd0;
         idx_q   <= 4'd0;
         ds_q    <= 1'b0;
         p_q     <= PARITY_NONE;
         s_q     <= 1'b0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         ds_q    <= ds_d;
         p_q     <= p_d;
         s_q     <= s_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   assign uart_tx_o = tx_q;

endmodule

// File: tb/tb_tx_frontend.sv
// tb_tx_frontend: self-checking bench for tx_frontend (table, random, corner sequences).
module tb_tx_frontend;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [15:0] cr_clk_div_i = 16'd0;
   logic        cr_ds_i = 1'b1;
   logic [1:0]  cr_p_i = 2'b00;
   logic        cr_s_i = 1'b0;
   logic [7:0]  data_i = 8'd0;
   logic        valid_i = 1'b0;
   logic        ready_o, uart_tx_o, busy_o;
`ifdef TX_BREAK_EN
   logic        break_i = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   tx_frontend dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cr_clk_div_i (cr_clk_div_i),
      .cr_ds_i      (cr_ds_i),
      .cr_p_i       (cr_p_i),
      .cr_s_i       (cr_s_i),
      .data_i       (data_i),
      .valid_i      (valid_i),
`ifdef TX_BREAK_EN
      .break_i      (break_i),
`endif
      .ready_o      (ready_o),
      .uart_tx_o    (uart_tx_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0]  d;
      logic [15:0] div;
      logic        ds;
      logic [1:0]  p;
      logic        s;
      logic [11:0] f;
      int          n;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference frame built directly from the frame rules, first bit in f[0].
   function automatic void model(input logic [7:0] d, input logic ds, input logic [1:0] p,
                                 input logic s, output logic [11:0] f, output int n);
      int nb;
      logic par;
      nb  = ds ? 8 : 7;
      f   = '1;
      n   = 0;
      par = 1'b0;
      f[n] = 1'b0; n++;
      for (int i = 0; i < nb; i++) begin
         f[n] = d[i];
         par ^= d[i];
         n++;
      end
      if (p != 2'b00) begin
         f[n] = (p == 2'b01) ? par : !par;
         n++;
      end
      for (int i = 0; i < (s ? 2 : 1); i++) begin
         f[n] = 1'b1;
         n++;
      end
   endfunction

   task automatic wait_ready(input string nm);
      int w = 0;
      while (!ready_o && w < 300) begin
         @(negedge clk_i);
         w++;
      end
      chk({nm, "_ready_wait"}, 32'(ready_o), 32'd1);
   endtask

   // Sends one word, scrambles CR/data right after acceptance, checks every bit cycle.
   task automatic send(input logic [7:0] d, input logic [15:0] div, input logic ds,
                       input logic [1:0] p, input logic s, input logic [11:0] f,
                       input int n, input string nm);
      int dd;
      @(negedge clk_i);
      wait_ready(nm);
      data_i = d; cr_clk_div_i = div; cr_ds_i = ds; cr_p_i = p; cr_s_i = s;
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      data_i = 8'($urandom);
      cr_clk_div_i = 16'($urandom_range(0, 7));
      cr_p_i = 2'($urandom);
      cr_ds_i = 1'($urandom);
      cr_s_i = 1'($urandom);
      dd = (div == 16'd0) ? 1 : int'(div);
      for (int i = 0; i < n * dd; i++) begin
         @(negedge clk_i);
         chk($sformatf("%s_bit%0d_cyc%0d", nm, i / dd, i), 32'(uart_tx_o), 32'(f[i / dd]));
         if (i == 0) begin
            chk({nm, "_ready_low"}, 32'(ready_o), 32'd0);
            chk({nm, "_busy_high"}, 32'(busy_o), 32'd1);
         end
      end
      @(negedge clk_i);
      chk({nm, "_end_tx"}, 32'(uart_tx_o), 32'd1);
      chk({nm, "_end_ready"}, 32'(ready_o), 32'd1);
      chk({nm, "_end_busy"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      #200_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] f;
      int n;
      logic [7:0] d;
      logic [15:0] div;
      logic ds, s;
      logic [1:0] p;

      tbl[0] = '{8'hA5, 16'd4, 1'b1, 2'b00, 1'b0, 12'h34A, 10};
      tbl[1] = '{8'h5A, 16'd3, 1'b1, 2'b01, 1'b0, 12'h4B4, 11};
      tbl[2] = '{8'h5A, 16'd3, 1'b1, 2'b10, 1'b1, 12'hEB4, 12};
      tbl[3] = '{8'hC1, 16'd2, 1'b0, 2'b10, 1'b0, 12'h382, 10};
      tbl[4] = '{8'h3C, 16'd0, 1'b1, 2'b00, 1'b1, 12'h678, 11};
      tbl[5] = '{8'h96, 16'd1, 1'b0, 2'b01, 1'b0, 12'h32C, 10};
      tbl[6] = '{8'h00, 16'd1, 1'b1, 2'b11, 1'b0, 12'h600, 11};

      #23;
      chk("reset_tx", 32'(uart_tx_o), 32'd1);
      chk("reset_ready", 32'(ready_o), 32'd1);
      chk("reset_busy", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("idle_tx", 32'(uart_tx_o), 32'd1);

      foreach (tbl[i])
         send(tbl[i].d, tbl[i].div, tbl[i].ds, tbl[i].p, tbl[i].s, tbl[i].f, tbl[i].n,
              $sformatf("tbl%0d", i));

      for (int k = 0; k < 40; k++) begin
         d = 8'($urandom);
         div = 16'($urandom_range(0, 4));
         ds = 1'($urandom);
         p = 2'($urandom);
         s = 1'($urandom);
         model(d, ds, p, s, f, n);
         send(d, div, ds, p, s, f, n, $sformatf("rnd%0d", k));
      end

      // Back-to-back with valid held: exactly one idle-high cycle between frames.
      @(negedge clk_i);
      wait_ready("b2b");
      data_i = 8'h33; cr_clk_div_i = 16'd2; cr_ds_i = 1'b1; cr_p_i = 2'b00; cr_s_i = 1'b0;
      valid_i = 1'b1;
      @(posedge clk_i);
      #1 data_i = 8'hCC;
      repeat (19) @(posedge clk_i);
      @(negedge clk_i);
      chk("b2b_last_stop", 32'(uart_tx_o), 32'd1);
      chk("b2b_still_busy", 32'(ready_o), 32'd0);
      @(negedge clk_i);
      chk("b2b_idle_gap", 32'(uart_tx_o), 32'd1);
      chk("b2b_ready", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      chk("b2b_second_start", 32'(uart_tx_o), 32'd0);
      chk("b2b_second_busy", 32'(ready_o), 32'd0);
      valid_i = 1'b0;
      @(negedge clk_i);
      chk("b2b_second_start2", 32'(uart_tx_o), 32'd0);
      @(negedge clk_i);
      chk("b2b_second_d0", 32'(uart_tx_o), 32'd0);
      wait_ready("b2b_end");

      // Reset pulsed in the middle of the data bits aborts the frame at once.
      @(negedge clk_i);
      data_i = 8'h00; cr_clk_div_i = 16'd4; cr_ds_i = 1'b1; cr_p_i = 2'b00; cr_s_i = 1'b0;
      valid_i = 1'b1;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #2;
      chk("rst_mid_line_low", 32'(uart_tx_o), 32'd0);
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_tx", 32'(uart_tx_o), 32'd1);
      chk("rst_mid_ready", 32'(ready_o), 32'd1);
      chk("rst_mid_busy", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      send(tbl[0].d, tbl[0].div, tbl[0].ds, tbl[0].p, tbl[0].s, tbl[0].f, tbl[0].n, "after_rst");

`ifdef TX_BREAK_EN
      // Break raised mid-frame: frame finishes, then the line is held low.
      @(negedge clk_i);
      model(8'h0F, 1'b1, 2'b00, 1'b0, f, n);
      data_i = 8'h0F; cr_clk_div_i = 16'd1; cr_ds_i = 1'b1; cr_p_i = 2'b00; cr_s_i = 1'b0;
      valid_i = 1'b1;
      @(posedge clk_i);
      #1 valid_i = 1'b0;
      break_i = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         chk($sformatf("brk_frame_bit%0d", i), 32'(uart_tx_o), 32'(f[i]));
      end
      @(negedge clk_i);
      chk("brk_idle_tx", 32'(uart_tx_o), 32'd1);
      chk("brk_idle_ready", 32'(ready_o), 32'd0);
      chk("brk_idle_busy", 32'(busy_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk($sformatf("brk_low%0d", i), 32'(uart_tx_o), 32'd0);
         chk($sformatf("brk_ready%0d", i), 32'(ready_o), 32'd0);
         chk($sformatf("brk_busy%0d", i), 32'(busy_o), 32'd1);
      end
      break_i = 1'b0;
      @(negedge clk_i);
      chk("brk_rel_tx", 32'(uart_tx_o), 32'd1);
      chk("brk_rel_ready", 32'(ready_o), 32'd0);
      @(negedge clk_i);
      chk("brk_rel2_tx", 32'(uart_tx_o), 32'd1);
      chk("brk_rel2_ready", 32'(ready_o), 32'd1);
      send(tbl[3].d, tbl[3].div, tbl[3].ds, tbl[3].p, tbl[3].s, tbl[3].f, tbl[3].n, "after_brk");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
